// File: rtl/wb_stage_param.sv
`default_nettype none
// ============================================================================
// Module   : wb_stage_param
// Brief    : MIPS MEM/WB stage register, load formatting, writeback select and
//            register-file port arbitration against a buffered MDU result FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module wb_stage_param #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       stall,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_pc,
    input  logic [31:0]                in_instr,
    input  logic                       in_reg_we,
    input  logic [ADDR_W-1:0]          in_reg_addr,
    input  logic [1:0]                 in_wsel,
    input  logic [2:0]                 in_ld_mode,
    input  logic [DATA_W-1:0]          in_alu_result,
    input  logic [DATA_W-1:0]          in_mem_data,
    input  logic                       mdu_valid,
    output logic                       mdu_ready,
    input  logic [ADDR_W-1:0]          mdu_addr,
    input  logic [DATA_W-1:0]          mdu_data,
    output logic                       reg_write_en,
    output logic [ADDR_W-1:0]          reg_write_addr,
    output logic [DATA_W-1:0]          reg_write_data,
    output logic [DATA_W-1:0]          wb_pc,
    output logic [31:0]                wb_instr,
    output logic [$clog2(DEPTH+1)-1:0] buf_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] c_depth    = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] c_last_ptr = PTR_W'(DEPTH - 1);

    localparam logic [1:0] c_wsel_mem  = 2'd1;
    localparam logic [1:0] c_wsel_link = 2'd2;
    localparam logic [2:0] c_ld_lb     = 3'd1;
    localparam logic [2:0] c_ld_lbu    = 3'd2;
    localparam logic [2:0] c_ld_lh     = 3'd3;
    localparam logic [2:0] c_ld_lhu    = 3'd4;

    logic              r_valid;
    logic [DATA_W-1:0] r_pc;
    logic [31:0]       r_instr;
    logic              r_reg_we;
    logic [ADDR_W-1:0] r_reg_addr;
    logic [1:0]        r_wsel;
    logic [2:0]        r_ld_mode;
    logic [DATA_W-1:0] r_alu;
    logic [DATA_W-1:0] r_mem;

    logic [ADDR_W-1:0] r_fifo_addr [DEPTH];
    logic [DATA_W-1:0] r_fifo_data [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic [1:0]        w_lane;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [DATA_W-1:0] w_load_data;
    logic [DATA_W-1:0] w_pipe_data;
    logic              w_pipe_we;
    logic              w_push;
    logic              w_pop;

    // Flush overrides stall only for the valid bit; payload follows stall.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_instr    <= '0;
            r_reg_we   <= 1'b0;
            r_reg_addr <= '0;
            r_wsel     <= '0;
            r_ld_mode  <= '0;
            r_alu      <= '0;
            r_mem      <= '0;
        end else begin
            if (flush) begin
                r_valid <= 1'b0;
            end else if (!stall) begin
                r_valid <= in_valid;
            end
            if (!stall) begin
                r_pc       <= in_pc;
                r_instr    <= in_instr;
                r_reg_we   <= in_reg_we;
                r_reg_addr <= in_reg_addr;
                r_wsel     <= in_wsel;
                r_ld_mode  <= in_ld_mode;
                r_alu      <= in_alu_result;
                r_mem      <= in_mem_data;
            end
        end
    end

    always_comb begin
        w_lane      = r_alu[1:0];
        w_byte      = r_mem[{w_lane, 3'b000} +: 8];
        w_half      = r_mem[{w_lane[1], 4'b0000} +: 16];
        w_load_data = r_mem;
        case (r_ld_mode)
            c_ld_lb:  w_load_data = {{(DATA_W-8){w_byte[7]}}, w_byte};
            c_ld_lbu: w_load_data = {{(DATA_W-8){1'b0}}, w_byte};
            c_ld_lh:  w_load_data = {{(DATA_W-16){w_half[15]}}, w_half};
            c_ld_lhu: w_load_data = {{(DATA_W-16){1'b0}}, w_half};
            default:  w_load_data = r_mem;
        endcase
    end

    always_comb begin
        case (r_wsel)
            c_wsel_mem:  w_pipe_data = w_load_data;
            c_wsel_link: w_pipe_data = r_pc + DATA_W'(8);
            default:     w_pipe_data = r_alu;
        endcase
    end

    assign w_pipe_we = r_valid & r_reg_we & (r_reg_addr != '0);
    assign mdu_ready = reset_n & (r_count < c_depth);
    assign w_push    = mdu_valid & mdu_ready;
    // The pipeline owns the port whenever it writes; the FIFO drains otherwise.
    assign w_pop     = ~w_pipe_we & (r_count != '0);

    always_comb begin
        reg_write_en   = 1'b0;
        reg_write_addr = '0;
        reg_write_data = '0;
        if (w_pipe_we) begin
            reg_write_en   = 1'b1;
            reg_write_addr = r_reg_addr;
            reg_write_data = w_pipe_data;
        end else if (w_pop && (r_fifo_addr[r_rd_ptr] != '0)) begin
            reg_write_en   = 1'b1;
            reg_write_addr = r_fifo_addr[r_rd_ptr];
            reg_write_data = r_fifo_data[r_rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= mdu_addr;
            r_fifo_data[r_wr_ptr] <= mdu_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign wb_pc     = r_pc;
    assign wb_instr  = r_instr;
    assign buf_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_wb_stage_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_stage_param
// Brief    : Self-checking bench for wb_stage_param with a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_stage_param;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 2;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              stall = 1'b0;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic [31:0]       in_pc = '0;
    logic [31:0]       in_instr = '0;
    logic              in_reg_we = 1'b0;
    logic [4:0]        in_reg_addr = '0;
    logic [1:0]        in_wsel = '0;
    logic [2:0]        in_ld_mode = '0;
    logic [31:0]       in_alu_result = '0;
    logic [31:0]       in_mem_data = '0;
    logic              mdu_valid = 1'b0;
    logic              mdu_ready;
    logic [4:0]        mdu_addr = '0;
    logic [31:0]       mdu_data = '0;
    logic              reg_write_en;
    logic [4:0]        reg_write_addr;
    logic [31:0]       reg_write_data;
    logic [31:0]       wb_pc;
    logic [31:0]       wb_instr;
    logic [CNT_W-1:0]  buf_count;

    int n_cmp  = 0;
    int n_fail = 0;

    wb_stage_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
        .in_reg_we(in_reg_we), .in_reg_addr(in_reg_addr), .in_wsel(in_wsel),
        .in_ld_mode(in_ld_mode), .in_alu_result(in_alu_result),
        .in_mem_data(in_mem_data), .mdu_valid(mdu_valid), .mdu_ready(mdu_ready),
        .mdu_addr(mdu_addr), .mdu_data(mdu_data), .reg_write_en(reg_write_en),
        .reg_write_addr(reg_write_addr), .reg_write_data(reg_write_data),
        .wb_pc(wb_pc), .wb_instr(wb_instr), .buf_count(buf_count)
    );

    always #5 clk = ~clk;

    // Behavioural model: a struct for the stage and a queue for MDU results.
    typedef struct {
        logic        v;
        logic [31:0] pc, instr, alu, mem;
        logic        we;
        logic [4:0]  addr;
        logic [1:0]  wsel;
        logic [2:0]  ld;
    } stage_t;
    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } ent_t;

    stage_t m_st;
    ent_t   m_q[$];

    function automatic logic [31:0] m_fmt(input logic [2:0] mode, input logic [31:0] alu, input logic [31:0] mem);
        int unsigned a = alu % 4;
        logic [31:0] b = (mem >> (8 * a)) & 32'hFF;
        logic [31:0] h = (mem >> (16 * (a / 2))) & 32'hFFFF;
        case (mode)
            3'd1:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd2:    return b;
            3'd3:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd4:    return h;
            default: return mem;
        endcase
    endfunction

    function automatic bit m_pipe();
        return m_st.v && m_st.we && (m_st.addr != 0);
    endfunction

    function automatic logic [37:0] m_expect();
        logic [31:0] d;
        if (m_pipe()) begin
            if (m_st.wsel == 2'd1)      d = m_fmt(m_st.ld, m_st.alu, m_st.mem);
            else if (m_st.wsel == 2'd2) d = m_st.pc + 32'd8;
            else                        d = m_st.alu;
            return {1'b1, m_st.addr, d};
        end
        if (m_q.size() > 0 && m_q[0].addr != 0) return {1'b1, m_q[0].addr, m_q[0].data};
        return '0;
    endfunction

    task automatic model_reset();
        m_st = '{v: 1'b0, pc: '0, instr: '0, alu: '0, mem: '0, we: 1'b0, addr: '0, wsel: '0, ld: '0};
        m_q.delete();
    endtask

    task automatic model_edge();
        bit pipe  = m_pipe();
        bit ready = (m_q.size() < DEPTH);
        if (!pipe && m_q.size() > 0) void'(m_q.pop_front());
        if (mdu_valid && ready) m_q.push_back('{addr: mdu_addr, data: mdu_data});
        if (!stall) begin
            m_st.pc = in_pc; m_st.instr = in_instr; m_st.alu = in_alu_result;
            m_st.mem = in_mem_data; m_st.we = in_reg_we; m_st.addr = in_reg_addr;
            m_st.wsel = in_wsel; m_st.ld = in_ld_mode; m_st.v = in_valid;
        end
        if (flush) m_st.v = 1'b0;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_stage(input logic v, input logic we, input logic [4:0] addr,
                               input logic [1:0] wsel, input logic [2:0] ld,
                               input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc);
        in_valid = v; in_reg_we = we; in_reg_addr = addr; in_wsel = wsel;
        in_ld_mode = ld; in_alu_result = alu; in_mem_data = mem; in_pc = pc;
        in_instr = pc ^ 32'hA5A5_0000;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        model_reset();
        #12;
        n_cmp++;
        if ({reg_write_en, reg_write_addr, reg_write_data} !== 38'd0) begin
            n_fail++; $display("FAIL reset_write: got %h want 0", {reg_write_en, reg_write_addr, reg_write_data});
        end
        n_cmp++;
        if ({mdu_ready, buf_count, wb_pc, wb_instr} !== '0) begin
            n_fail++; $display("FAIL reset_state: ready=%b count=%0d pc=%h instr=%h want all 0", mdu_ready, buf_count, wb_pc, wb_instr);
        end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        n_cmp++;
        if (mdu_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_release_ready: got %b want 1", mdu_ready);
        end
    endtask

    task automatic test_load_format();
        logic [2:0]  modes [7] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1, 3'd5};
        logic [31:0] alus  [7] = '{32'h1, 32'h1, 32'h2, 32'h2, 32'h3, 32'h0, 32'h2};
        logic [31:0] exps  [7] = '{32'hFFFF_FF82, 32'h0000_0082, 32'hFFFF_8081, 32'h0000_8081,
                                   32'h8081_8283, 32'hFFFF_FF83, 32'h8081_8283};
        for (int i = 0; i < 7; i++) begin
            drive_stage(1'b1, 1'b1, 5'd5, 2'd1, modes[i], alus[i], 32'h8081_8283, 32'h100 + 32'(i));
            tick();
            n_cmp++;
            if ({reg_write_en, reg_write_addr, reg_write_data} !== {1'b1, 5'd5, exps[i]}) begin
                n_fail++; $display("FAIL load_mode%0d_lane%0d: got en=%b a=%0d d=%h want en=1 a=5 d=%h",
                                   modes[i], alus[i], reg_write_en, reg_write_addr, reg_write_data, exps[i]);
            end
        end
        drive_stage(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, '0, '0, '0);
        tick();
    endtask

    task automatic test_link();
        drive_stage(1'b1, 1'b1, 5'd31, 2'd2, 3'd0, 32'hDEAD, 32'hBEEF, 32'h0000_3000);
        tick();
        n_cmp++;
        if ({reg_write_en, reg_write_addr, reg_write_data} !== {1'b1, 5'd31, 32'h0000_3008}) begin
            n_fail++; $display("FAIL link_r31: got en=%b a=%0d d=%h want en=1 a=31 d=00003008", reg_write_en, reg_write_addr, reg_write_data);
        end
        n_cmp++;
        if (wb_pc !== 32'h0000_3000) begin
            n_fail++; $display("FAIL link_wb_pc: got %h want 00003000", wb_pc);
        end
        drive_stage(1'b1, 1'b1, 5'd0, 2'd2, 3'd0, 32'hDEAD, 32'hBEEF, 32'h0000_3000);
        tick();
        n_cmp++;
        if ({reg_write_en, reg_write_addr, reg_write_data} !== 38'd0) begin
            n_fail++; $display("FAIL link_r0: got en=%b a=%0d d=%h want all 0", reg_write_en, reg_write_addr, reg_write_data);
        end
        drive_stage(1'b1, 1'b1, 5'd9, 2'd2, 3'd0, '0, '0, 32'hFFFF_FFFC);
        tick();
        n_cmp++;
        if (reg_write_data !== 32'h0000_0004) begin
            n_fail++; $display("FAIL link_wrap: got %h want 00000004", reg_write_data);
        end
        drive_stage(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, '0, '0, '0);
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] d [3] = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};
        drive_stage(1'b1, 1'b1, 5'd3, 2'd0, 3'd0, 32'h1111, '0, 32'h200);
        for (int i = 0; i < 3; i++) begin
            mdu_valid = 1'b1; mdu_addr = 5'(10 + i); mdu_data = d[i];
            tick();
            n_cmp++;
            if ({reg_write_en, reg_write_addr, buf_count, mdu_ready} !== {1'b1, 5'd3, CNT_W'(i < 2 ? i + 1 : 2), (i == 0)}) begin
                n_fail++; $display("FAIL b2b_fill%0d: got en=%b a=%0d cnt=%0d rdy=%b", i, reg_write_en, reg_write_addr, buf_count, mdu_ready);
            end
        end
        in_valid = 1'b0;
        tick();
        n_cmp++;
        if ({reg_write_en, reg_write_addr, reg_write_data, buf_count, mdu_ready} !== {1'b1, 5'd10, d[0], CNT_W'(2), 1'b0}) begin
            n_fail++; $display("FAIL b2b_drain0: got en=%b a=%0d d=%h cnt=%0d rdy=%b", reg_write_en, reg_write_addr, reg_write_data, buf_count, mdu_ready);
        end
        tick();
        n_cmp++;
        if ({reg_write_addr, reg_write_data, buf_count, mdu_ready} !== {5'd11, d[1], CNT_W'(1), 1'b1}) begin
            n_fail++; $display("FAIL b2b_full_pop_refuse: got a=%0d d=%h cnt=%0d rdy=%b want a=11 cnt=1 rdy=1", reg_write_addr, reg_write_data, buf_count, mdu_ready);
        end
        tick();
        n_cmp++;
        if ({reg_write_en, reg_write_addr, reg_write_data, buf_count} !== {1'b1, 5'd12, d[2], CNT_W'(1)}) begin
            n_fail++; $display("FAIL b2b_accept_late: got en=%b a=%0d d=%h cnt=%0d", reg_write_en, reg_write_addr, reg_write_data, buf_count);
        end
        mdu_valid = 1'b0;
        tick();
        n_cmp++;
        if ({reg_write_en, buf_count} !== {1'b0, CNT_W'(0)}) begin
            n_fail++; $display("FAIL b2b_empty: got en=%b cnt=%0d want 0 0", reg_write_en, buf_count);
        end
    endtask

    task automatic test_stall_flush();
        drive_stage(1'b1, 1'b1, 5'd4, 2'd0, 3'd0, 32'h4444, '0, 32'h300);
        mdu_valid = 1'b1; mdu_addr = 5'd20; mdu_data = 32'hD00D_0020;
        tick();
        mdu_valid = 1'b0;
        stall = 1'b1;
        in_alu_result = 32'h9999; in_reg_addr = 5'd6;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if ({reg_write_en, reg_write_addr, reg_write_data, buf_count} !== {1'b1, 5'd4, 32'h4444, CNT_W'(1)}) begin
                n_fail++; $display("FAIL stall_hold%0d: got en=%b a=%0d d=%h cnt=%0d", i, reg_write_en, reg_write_addr, reg_write_data, buf_count);
            end
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_cmp++;
        if ({reg_write_en, reg_write_addr, reg_write_data} !== {1'b1, 5'd20, 32'hD00D_0020}) begin
            n_fail++; $display("FAIL stall_flush_drain: got en=%b a=%0d d=%h want en=1 a=20 d=d00d0020", reg_write_en, reg_write_addr, reg_write_data);
        end
        tick();
        n_cmp++;
        if ({reg_write_en, buf_count} !== {1'b0, CNT_W'(0)}) begin
            n_fail++; $display("FAIL stall_flush_after: got en=%b cnt=%0d want 0 0", reg_write_en, buf_count);
        end
        stall = 1'b0;
        drive_stage(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, '0, '0, '0);
        tick();
    endtask

    task automatic test_reset_midop();
        drive_stage(1'b1, 1'b1, 5'd7, 2'd0, 3'd0, 32'h7777, '0, 32'h400);
        mdu_valid = 1'b1; mdu_addr = 5'd21; mdu_data = 32'h1;
        tick();
        mdu_addr = 5'd22; mdu_data = 32'h2;
        tick();
        mdu_valid = 1'b0;
        in_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        n_cmp++;
        if ({reg_write_en, reg_write_addr, reg_write_data, buf_count, mdu_ready, wb_pc} !== '0) begin
            n_fail++; $display("FAIL reset_midop: got en=%b a=%0d d=%h cnt=%0d rdy=%b pc=%h want all 0",
                               reg_write_en, reg_write_addr, reg_write_data, buf_count, mdu_ready, wb_pc);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if ({reg_write_en, buf_count, mdu_ready} !== {1'b0, CNT_W'(0), 1'b1}) begin
                n_fail++; $display("FAIL reset_midop_after%0d: got en=%b cnt=%0d rdy=%b", i, reg_write_en, buf_count, mdu_ready);
            end
        end
    endtask

    task automatic test_random();
        logic [37:0] exp_w;
        for (int i = 0; i < 400; i++) begin
            drive_stage(($urandom % 4) != 0, ($urandom % 4) != 0, 5'($urandom_range(0, 7)),
                        2'($urandom), 3'($urandom), $urandom, $urandom, $urandom);
            stall     = ($urandom % 8) == 0;
            flush     = ($urandom % 8) == 0;
            mdu_valid = ($urandom % 2) == 0;
            mdu_addr  = 5'($urandom_range(0, 3));
            mdu_data  = $urandom;
            tick();
            exp_w = m_expect();
            n_cmp++;
            if ({reg_write_en, reg_write_addr, reg_write_data} !== exp_w) begin
                n_fail++; $display("FAIL rand_write@%0d: got %h want %h", i, {reg_write_en, reg_write_addr, reg_write_data}, exp_w);
            end
            n_cmp++;
            if ({mdu_ready, buf_count} !== {(m_q.size() < DEPTH), CNT_W'(m_q.size())}) begin
                n_fail++; $display("FAIL rand_buf@%0d: got rdy=%b cnt=%0d want cnt=%0d", i, mdu_ready, buf_count, m_q.size());
            end
            n_cmp++;
            if ({wb_pc, wb_instr} !== {m_st.pc, m_st.instr}) begin
                n_fail++; $display("FAIL rand_trace@%0d: got pc=%h instr=%h want pc=%h instr=%h", i, wb_pc, wb_instr, m_st.pc, m_st.instr);
            end
        end
        stall = 1'b0; flush = 1'b0; mdu_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_format();
        test_link();
        test_back_to_back();
        test_stall_flush();
        test_reset_midop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
